stream_in_pack: RTL

//  Parametrised narrow-to-wide stream packer in front of the AES datapath.
//  - Gathers BEATS = BLK_W/DIN_W input beats into one BLK_W block. First beat lands in the MSBs.
//  - Carries the block type, and supports early termination (lin) with zero padding.
//  - Has a one-block output register with valid/ready backpressure, so key/data loading can stall.

---
 rtl/stream_in_pack_pkg.sv | 20 ++
 rtl/stream_in_pack_if.sv | 33 +++
 rtl/stream_pack_acc.sv | 60 ++++++
 rtl/stream_in_pack.sv | 85 ++++++++
 4 files changed

// File: rtl/stream_in_pack_pkg.sv
// Shared definitions for the stream packer: default widths, block type codes
// and the counter-width helper.
package stream_in_pack_pkg;

    localparam int DEF_DIN_W  = 16;
    localparam int DEF_BLK_W  = 128;
    localparam int DEF_TYPE_W = 2;

    typedef enum logic [1:0] {
        TYPE_KEY = 2'b00,
        TYPE_PT  = 2'b01,
        TYPE_CT  = 2'b10
    } blk_type_e;

    // Counter must be able to hold the beat count 1..beats.
    function automatic int cnt_width(input int beats);
        return $clog2(beats + 1);
    endfunction

endpackage

// File: rtl/stream_in_pack_if.sv
// Handshake bundle for the packer: narrow beat stream in, wide block stream out.
interface stream_in_pack_if
    import stream_in_pack_pkg::*;
#(
    parameter int DIN_W  = DEF_DIN_W,
    parameter int BLK_W  = DEF_BLK_W,
    parameter int TYPE_W = DEF_TYPE_W
) ();
    localparam int BEATS = BLK_W / DIN_W;
    localparam int CNT_W = cnt_width(BEATS);

    logic              vin;
    logic              rin;
    logic [TYPE_W-1:0] tin;
    logic              lin;
    logic [DIN_W-1:0]  din;
    logic              vout;
    logic              rout;
    logic [TYPE_W-1:0] tout;
    logic [BLK_W-1:0]  dout;
    logic [CNT_W-1:0]  nbeat;

    modport slave (
        input  vin, tin, lin, din, rout,
        output rin, vout, tout, dout, nbeat
    );

    modport master (
        output vin, tin, lin, din, rout,
        input  rin, vout, tout, dout, nbeat
    );

endinterface

// File: rtl/stream_pack_acc.sv
// Shift accumulator with beat counter; presents the left-aligned block that the
// current beat would complete.
module stream_pack_acc
    import stream_in_pack_pkg::*;
#(
    parameter int DIN_W = DEF_DIN_W,
    parameter int BLK_W = DEF_BLK_W,
    localparam int BEATS = BLK_W / DIN_W,
    localparam int CNT_W = cnt_width(BEATS)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             beat_i,
    input  logic             lin_i,
    input  logic [DIN_W-1:0] din_i,
    output logic             first_o,
    output logic             done_o,
    output logic [BLK_W-1:0] blk_o,
    output logic [CNT_W-1:0] nbeat_o
);

    logic [BLK_W-1:0] acc_q, acc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    assign acc_d   = {acc_q[BLK_W-DIN_W-1:0], din_i};
    assign first_o = (cnt_q == '0);
    assign done_o  = beat_i & (lin_i | (cnt_q == CNT_W'(BEATS - 1)));
    assign nbeat_o = cnt_q + CNT_W'(1);

    always_comb begin
        cnt_d = cnt_q;
        if (beat_i) begin
            cnt_d = done_o ? '0 : cnt_q + CNT_W'(1);
        end
    end

    // Stale beats from earlier blocks sit above the newest k beats and are
    // shifted out, so no explicit clear of the accumulator is needed.
    always_comb begin
        blk_o = '0;
        for (int i = 0; i < BEATS; i++) begin
            if (cnt_q == CNT_W'(i)) begin
                blk_o = acc_d << ((BEATS - 1 - i) * DIN_W);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q <= '0;
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
            if (beat_i) begin
                acc_q <= acc_d;
            end
        end
    end

endmodule

// File: rtl/stream_in_pack.sv
// Narrow-to-wide stream packer: block type capture, one-deep output register
// with valid/ready backpressure, and input ready gating.
module stream_in_pack
    import stream_in_pack_pkg::*;
#(
    parameter int DIN_W  = DEF_DIN_W,
    parameter int BLK_W  = DEF_BLK_W,
    parameter int TYPE_W = DEF_TYPE_W,
    localparam int BEATS = BLK_W / DIN_W,
    localparam int CNT_W = cnt_width(BEATS)
) (
    input  logic            clk,
    input  logic            rst_n,
    stream_in_pack_if.slave bus
);

    logic              beat;
    logic              first;
    logic              done;
    logic [BLK_W-1:0]  blk;
    logic [CNT_W-1:0]  nbeat_k;
    logic [TYPE_W-1:0] t_acc_q;
    logic [TYPE_W-1:0] tout_d, tout_q;
    logic              vout_d, vout_q;
    logic [BLK_W-1:0]  dout_q;
    logic [CNT_W-1:0]  nbeat_q;

    // All beats are gated, not just completing ones, keeping ready a simple
    // function of the output register.
    assign bus.rin = ~vout_q | bus.rout;
    assign beat    = bus.vin & bus.rin;

    stream_pack_acc #(
        .DIN_W (DIN_W),
        .BLK_W (BLK_W)
    ) u_acc (
        .clk     (clk),
        .rst_n   (rst_n),
        .beat_i  (beat),
        .lin_i   (bus.lin),
        .din_i   (bus.din),
        .first_o (first),
        .done_o  (done),
        .blk_o   (blk),
        .nbeat_o (nbeat_k)
    );

    assign tout_d = first ? bus.tin : t_acc_q;

    always_comb begin
        vout_d = vout_q;
        if (vout_q & bus.rout) begin
            vout_d = 1'b0;
        end
        if (done) begin
            vout_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            t_acc_q <= '0;
            vout_q  <= 1'b0;
            tout_q  <= '0;
            dout_q  <= '0;
            nbeat_q <= '0;
        end else begin
            vout_q <= vout_d;
            if (beat & first) begin
                t_acc_q <= bus.tin;
            end
            if (done) begin
                tout_q  <= tout_d;
                dout_q  <= blk;
                nbeat_q <= nbeat_k;
            end
        end
    end

    assign bus.vout  = vout_q;
    assign bus.tout  = tout_q;
    assign bus.dout  = dout_q;
    assign bus.nbeat = nbeat_q;

endmodule
